// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// INITIAL_PC may be overridden on the command line; it defaults to address zero.
`ifndef INITIAL_PC
`define INITIAL_PC 32'h0000_0000
`endif

package fetch_unit_pkg;

  localparam int unsigned      InstW     = 32;
  localparam logic [InstW-1:0] InstNop   = 32'h0000_0013;
  localparam logic [31:0]      InitialPc = `INITIAL_PC;

  typedef struct packed {
    logic [31:0]      pc;
    logic [InstW-1:0] inst;
  } fetch_entry_t;

  // Sequential successor; wraps 0xFFFFFFFC -> 0x00000000.
  function automatic logic [31:0] pc_incr(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Signals between the fetch stage and its PC register, instruction memory,
// decode stage and redirect source. The fetch stage uses the master modport.
interface fetch_unit_if #(
  parameter int unsigned ADDR_W = 32
) ();

  logic [ADDR_W-1:0] pc;
  logic              pc_write_enable;
  logic [ADDR_W-1:0] next_pc;

  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rsp_valid;
  logic [31:0]       imem_rsp_data;

  logic              inst_valid;
  logic              inst_ready;
  logic [31:0]       inst;
  logic [ADDR_W-1:0] inst_pc;

  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;

  modport master (
    input  pc,
    output pc_write_enable,
    output next_pc,
    output imem_req_valid,
    input  imem_req_ready,
    output imem_addr,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    output inst_valid,
    input  inst_ready,
    output inst,
    output inst_pc,
    input  redirect_valid,
    input  redirect_pc
  );

  modport slave (
    output pc,
    input  pc_write_enable,
    input  next_pc,
    input  imem_req_valid,
    output imem_req_ready,
    input  imem_addr,
    output imem_rsp_valid,
    output imem_rsp_data,
    input  inst_valid,
    output inst_ready,
    input  inst,
    input  inst_pc,
    output redirect_valid,
    output redirect_pc
  );

endinterface

// File: rtl/fetch_buffer.sv
// Synchronous FIFO of fetched {pc, word} entries with flush. DEPTH must be a power of two.
// Push and pop may coincide on a full or an empty buffer; flush wins over both.
module fetch_buffer
  import fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  fetch_entry_t    mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            do_push, do_pop;

  always_comb begin
    empty   = (cnt_q == '0);
    full    = (cnt_q == CntW'(DEPTH));
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      cnt_d = cnt_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Payload needs no reset: it is only observed while count is non-zero.
  always_ff @(posedge clock) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: credit-limited in-order requests, response tagging with the issued pc,
// redirect flush with discard of in-flight responses, and next_pc control for the PC register.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ADDR_W = 32
) (
  input  logic         clock,
  input  logic         reset,
  fetch_unit_if.master bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [CntW-1:0]   out_cnt_q, out_cnt_d;
  logic [CntW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [PtrW-1:0]   tag_wr_q, tag_wr_d;
  logic [PtrW-1:0]   tag_rd_q, tag_rd_d;
  logic [ADDR_W-1:0] tag_q [DEPTH];

  logic [CntW-1:0]   buf_count;
  logic              buf_full, buf_empty;
  fetch_entry_t      buf_head, rsp_entry;

  logic [CntW:0]     occupancy;
  logic              credit_ok, redirect, accept, rsp, dropping, push, pop;

  // Handshake decode. Redirect suppresses issue, push and pop in its cycle.
  always_comb begin
    redirect  = bus.redirect_valid;
    rsp       = bus.imem_rsp_valid;
    occupancy = {1'b0, out_cnt_q} + {1'b0, buf_count};
    credit_ok = occupancy < (CntW + 1)'(DEPTH);

    bus.imem_req_valid = !reset && !redirect && credit_ok;
    bus.imem_addr      = bus.pc;
    accept             = bus.imem_req_valid && bus.imem_req_ready;

    dropping = rsp && (drop_cnt_q != '0);
    push     = rsp && !dropping && !redirect;
    pop      = !buf_empty && bus.inst_ready && !redirect;
  end

  // Every response retires one outstanding request, dropped or not.
  always_comb begin
    out_cnt_d = out_cnt_q + CntW'(accept) - CntW'(rsp);
    tag_wr_d  = tag_wr_q + PtrW'(accept);
    tag_rd_d  = tag_rd_q + PtrW'(rsp);
    if (redirect) begin
      // Everything still in flight after this cycle belongs to the old path.
      drop_cnt_d = out_cnt_q - CntW'(rsp);
    end else begin
      drop_cnt_d = drop_cnt_q - CntW'(dropping);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
    end else begin
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      tag_wr_q   <= tag_wr_d;
      tag_rd_q   <= tag_rd_d;
    end
  end

  always_ff @(posedge clock) begin
    if (accept) tag_q[tag_wr_q] <= bus.pc;
  end

  // PC register control: redirect beats sequential advance; reset holds the initial pc.
  always_comb begin
    bus.pc_write_enable = 1'b0;
    bus.next_pc         = bus.pc;
    if (reset) begin
      bus.next_pc = InitialPc;
    end else if (redirect) begin
      bus.pc_write_enable = 1'b1;
      bus.next_pc         = bus.redirect_pc;
    end else if (accept) begin
      bus.pc_write_enable = 1'b1;
      bus.next_pc         = pc_incr(bus.pc);
    end
  end

  always_comb begin
    rsp_entry.pc   = tag_q[tag_rd_q];
    rsp_entry.inst = bus.imem_rsp_data;
  end

  fetch_buffer #(
    .DEPTH (DEPTH)
  ) u_buffer (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (rsp_entry),
    .pop       (pop),
    .flush     (redirect),
    .head      (buf_head),
    .count     (buf_count),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  assign bus.inst_valid = !buf_empty;
  assign bus.inst       = buf_empty ? InstNop : buf_head.inst;
  assign bus.inst_pc    = buf_head.pc;

  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (!(push && buf_full && !pop))
        else $error("fetch_unit: instruction buffer overflow");
      assert (!(rsp && out_cnt_q == '0))
        else $error("fetch_unit: response with nothing outstanding");
    end
  end

endmodule
